// File: rtl/stream_width_reducer.sv
// rtl/stream_width_reducer.sv - buffered wide-to-narrow stream reducer with partial words and frame marks
// Words queue in a small FIFO; a shift stage then emits each as DOUT_WIDTH sub-words.
module stream_width_reducer #(
   parameter int DIN_WIDTH  = 64,
   parameter int DOUT_WIDTH = 16,
   parameter int RATIO      = DIN_WIDTH / DOUT_WIDTH,
   parameter int DEPTH      = 4,
   parameter int ORDER      = 0,
   parameter int NW_WIDTH   = $clog2(RATIO + 1)
) (
   input  logic                         clk,
   input  logic                         resetn,
   input  logic [DIN_WIDTH-1:0]         din,
   input  logic                         din_valid,
   input  logic [NW_WIDTH-1:0]          din_nwords,
   input  logic                         din_last,
   output logic                         din_ready,
   output logic [DOUT_WIDTH-1:0]        dout,
   output logic                         dout_valid,
   output logic                         dout_last,
   input  logic                         dout_ready,
   output logic [$clog2(DEPTH+1)-1:0]   buf_count
);

   localparam int PTR_WIDTH = $clog2(DEPTH);
   localparam int CNT_WIDTH = $clog2(DEPTH + 1);

   localparam logic [0:0] S_IDLE  = 1'b0;
   localparam logic [0:0] S_SHIFT = 1'b1;

   logic [DIN_WIDTH-1:0] mem_data [DEPTH];
   logic [NW_WIDTH-1:0]  mem_nw   [DEPTH];
   logic                 mem_last [DEPTH];

   logic [PTR_WIDTH-1:0] wr_ptr;
   logic [PTR_WIDTH-1:0] rd_ptr;
   logic [CNT_WIDTH-1:0] count;
   logic                 full;
   logic                 empty;
   logic                 push;
   logic                 pop;
   logic                 xfer;

   logic [0:0]           state;
   logic [DIN_WIDTH-1:0] shreg;
   logic [NW_WIDTH-1:0]  rem;
   logic                 cur_last;

   logic [DIN_WIDTH-1:0] head_data;
   logic [NW_WIDTH-1:0]  head_nw;
   logic                 head_last;
   logic [DIN_WIDTH-1:0] src;
   logic [DIN_WIDTH-1:0] src_next;
   logic [DOUT_WIDTH-1:0] src_sub;

   // Occupancy counter drives full/empty so DEPTH need not be a power of two.
   assign full       = (count == CNT_WIDTH'(DEPTH));
   assign empty      = (count == '0);
   assign din_ready  = resetn && !full;
   assign push       = din_valid && din_ready;
   assign dout_valid = (state == S_SHIFT);
   assign xfer       = dout_valid && dout_ready;
   assign pop        = !empty && ((state == S_IDLE) || (xfer && (rem == NW_WIDTH'(1))));
   assign buf_count  = count;

   assign head_data  = mem_data[rd_ptr];
   assign head_last  = mem_last[rd_ptr];

   always_comb begin
      head_nw = mem_nw[rd_ptr];
      if ((head_nw == '0) || (head_nw > NW_WIDTH'(RATIO))) begin
         head_nw = NW_WIDTH'(RATIO);
      end
   end

   // The shifter always presents its next sub-word at one fixed end of the register.
   always_comb begin
      src = pop ? head_data : shreg;
      if (ORDER != 0) begin
         src_sub  = src[DIN_WIDTH-1 -: DOUT_WIDTH];
         src_next = src << DOUT_WIDTH;
      end else begin
         src_sub  = src[DOUT_WIDTH-1:0];
         src_next = src >> DOUT_WIDTH;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_data[i] <= '0;
            mem_nw[i]   <= '0;
            mem_last[i] <= 1'b0;
         end
      end else begin
         if (push) begin
            mem_data[wr_ptr] <= din;
            mem_nw[wr_ptr]   <= din_nwords;
            mem_last[wr_ptr] <= din_last;
            wr_ptr <= (wr_ptr == PTR_WIDTH'(DEPTH - 1)) ? '0 : wr_ptr + PTR_WIDTH'(1);
         end
         if (pop) begin
            rd_ptr <= (rd_ptr == PTR_WIDTH'(DEPTH - 1)) ? '0 : rd_ptr + PTR_WIDTH'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CNT_WIDTH'(1);
            2'b01:   count <= count - CNT_WIDTH'(1);
            default: count <= count;
         endcase
      end
   end

   // A pop on the final transfer reloads in the same edge, so back-to-back words have no bubble.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state     <= S_IDLE;
         shreg     <= '0;
         rem       <= '0;
         cur_last  <= 1'b0;
         dout      <= '0;
         dout_last <= 1'b0;
      end else if (pop) begin
         state     <= S_SHIFT;
         shreg     <= src_next;
         dout      <= src_sub;
         rem       <= head_nw;
         cur_last  <= head_last;
         dout_last <= head_last && (head_nw == NW_WIDTH'(1));
      end else if (xfer) begin
         if (rem > NW_WIDTH'(1)) begin
            shreg     <= src_next;
            dout      <= src_sub;
            rem       <= rem - NW_WIDTH'(1);
            dout_last <= cur_last && (rem == NW_WIDTH'(2));
         end else begin
            state     <= S_IDLE;
            shreg     <= '0;
            rem       <= '0;
            cur_last  <= 1'b0;
            dout      <= '0;
            dout_last <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_stream_width_reducer.sv
// tb/tb_stream_width_reducer.sv - directed bench for stream_width_reducer, both sub-word orders
module tb_stream_width_reducer;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        resetn;
   logic [63:0] din;
   logic        din_valid;
   logic [2:0]  din_nwords;
   logic        din_last;
   logic        dout_ready;

   logic        din_ready0, din_ready1;
   logic [15:0] dout0, dout1;
   logic        dout_valid0, dout_valid1;
   logic        dout_last0, dout_last1;
   logic [2:0]  buf_count0, buf_count1;

   int checks = 0;
   int errors = 0;

   logic [15:0] t2_exp0 [4] = '{16'h0404, 16'h3232, 16'h0000, 16'hFFFF};
   logic [15:0] t2_exp1 [4] = '{16'hFFFF, 16'h0000, 16'h3232, 16'h0404};

   stream_width_reducer #(.DIN_WIDTH(64), .DOUT_WIDTH(16), .DEPTH(4), .ORDER(0)) u_dut0 (
      .clk(clk), .resetn(resetn), .din(din), .din_valid(din_valid), .din_nwords(din_nwords),
      .din_last(din_last), .din_ready(din_ready0), .dout(dout0), .dout_valid(dout_valid0),
      .dout_last(dout_last0), .dout_ready(dout_ready), .buf_count(buf_count0)
   );

   stream_width_reducer #(.DIN_WIDTH(64), .DOUT_WIDTH(16), .DEPTH(4), .ORDER(1)) u_dut1 (
      .clk(clk), .resetn(resetn), .din(din), .din_valid(din_valid), .din_nwords(din_nwords),
      .din_last(din_last), .din_ready(din_ready1), .dout(dout1), .dout_valid(dout_valid1),
      .dout_last(dout_last1), .dout_ready(dout_ready), .buf_count(buf_count1)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   function automatic logic [63:0] mk_word(input logic [15:0] base);
      return {base + 16'd3, base + 16'd2, base + 16'd1, base};
   endfunction

   task automatic chk_all_zero(input string tag);
      chk({tag, "_dut0"}, {din_ready0, dout_valid0, dout_last0, dout0, buf_count0}, 64'd0);
      chk({tag, "_dut1"}, {din_ready1, dout_valid1, dout_last1, dout1, buf_count1}, 64'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc;
      int n;
      int first;
      int lastc;
      logic acc_now;
      logic found;

      // Reset held with traffic offered on both sides
      resetn     = 1'b0;
      din_valid  = 1'b1;
      dout_ready = 1'b1;
      din        = 64'hDEAD_BEEF_0123_4567;
      din_nwords = 3'd0;
      din_last   = 1'b1;
      repeat (5) begin
         tick();
         chk_all_zero("rst_out");
      end
      din_valid = 1'b0;
      resetn    = 1'b1;
      #1;
      chk("rel_din_ready", din_ready0, 1);
      chk("rel_dout_valid", dout_valid0, 0);
      chk("rel_buf_count", buf_count0, 0);

      // Full word, both orders
      din        = 64'hFFFF_0000_3232_0404;
      din_nwords = 3'd0;
      din_last   = 1'b1;
      din_valid  = 1'b1;
      tick();
      din_valid = 1'b0;
      chk("t2_not_yet_valid", dout_valid0, 0);
      chk("t2_buf_one", buf_count0, 1);
      tick();
      for (int k = 0; k < 4; k++) begin
         chk("t2_valid0", dout_valid0, 1);
         chk("t2_dout0", dout0, t2_exp0[k]);
         chk("t2_last0", dout_last0, (k == 3));
         chk("t2_dout1", dout1, t2_exp1[k]);
         chk("t2_last1", dout_last1, (k == 3));
         tick();
      end
      chk("t2_idle0", dout_valid0, 0);
      chk("t2_idle1", dout_valid1, 0);

      // Partial word of two sub-words
      din_nwords = 3'd2;
      din_valid  = 1'b1;
      tick();
      din_valid = 1'b0;
      tick();
      chk("t3_dout1_a", dout1, 16'hFFFF);
      chk("t3_last1_a", dout_last1, 0);
      chk("t3_dout0_a", dout0, 16'h0404);
      tick();
      chk("t3_dout1_b", dout1, 16'h0000);
      chk("t3_last1_b", dout_last1, 1);
      chk("t3_dout0_b", dout0, 16'h3232);
      chk("t3_last0_b", dout_last0, 1);
      repeat (3) begin
         tick();
         chk("t3_no_more0", dout_valid0, 0);
         chk("t3_no_more1", dout_valid1, 0);
      end

      // Backpressure fills shifter plus FIFO
      dout_ready = 1'b0;
      din_nwords = 3'd0;
      acc = 0;
      for (int c = 0; c < 12; c++) begin
         din_valid = 1'b1;
         din       = mk_word(16'(acc * 4));
         din_last  = (acc == 4);
         acc_now   = din_ready0;
         tick();
         if (acc_now) acc++;
         if (dout_valid0) begin
            chk("t4_hold0", dout0, 16'h0000);
            chk("t4_hold1", dout1, 16'h0003);
         end
      end
      chk("t4_accepts", acc, 5);
      chk("t4_din_ready0", din_ready0, 0);
      chk("t4_buf0", buf_count0, 4);
      chk("t4_din_ready1", din_ready1, 0);
      chk("t4_buf1", buf_count1, 4);
      din_valid  = 1'b0;
      dout_ready = 1'b1;
      for (int k = 0; k < 20; k++) begin
         chk("t4_drain_valid", dout_valid0, 1);
         chk("t4_drain_dout0", dout0, 16'(k));
         chk("t4_drain_dout1", dout1, 16'(4 * (k / 4) + 3 - (k % 4)));
         chk("t4_drain_last", dout_last0, (k == 19));
         chk("t4_drain_buf", buf_count0, 4 - k / 4);
         tick();
      end
      chk("t4_drained", dout_valid0, 0);

      // Eight words back to back, pointers wrap
      acc   = 0;
      n     = 0;
      first = -1;
      lastc = -1;
      for (int c = 0; c < 80; c++) begin
         din_valid  = (acc < 8);
         din        = mk_word(16'(16'h1000 + acc * 4));
         din_last   = (acc == 7);
         acc_now    = din_valid && din_ready0;
         tick();
         if (acc_now) acc++;
         if (dout_valid0) begin
            if (first < 0) first = c;
            lastc = c;
            chk("t5_dout0", dout0, 16'(16'h1000 + n));
            chk("t5_dout1", dout1, 16'(16'h1000 + 4 * (n / 4) + 3 - (n % 4)));
            chk("t5_last0", dout_last0, (n == 31));
            n++;
         end
      end
      din_valid = 1'b0;
      chk("t5_accepts", acc, 8);
      chk("t5_count", n, 32);
      chk("t5_no_gaps", lastc - first + 1, 32);

      // Reset while the second sub-word of a buffered burst is showing
      din_last = 1'b0;
      acc      = 0;
      found    = 1'b0;
      for (int c = 0; c < 20 && !found; c++) begin
         din_valid = (acc < 3);
         din       = mk_word(16'(16'h2000 + acc * 4));
         din_last  = (acc == 2);
         acc_now   = din_valid && din_ready0;
         tick();
         if (acc_now) acc++;
         if (dout_valid0 && dout0 == 16'h2001) found = 1'b1;
      end
      din_valid = 1'b0;
      chk("t6_reached", found, 1);
      chk("t6_buf_before", buf_count0, 2);
      chk("t6_dout1_before", dout1, 16'h2002);
      resetn = 1'b0;
      #1;
      chk_all_zero("t6_async");
      repeat (2) begin
         tick();
         chk_all_zero("t6_held");
      end
      resetn = 1'b1;
      #1;
      chk("t6_rel_ready", din_ready0, 1);
      chk("t6_rel_buf", buf_count0, 0);
      repeat (8) begin
         tick();
         chk("t6_stale0", dout_valid0, 0);
         chk("t6_stale1", dout_valid1, 0);
         chk("t6_buf", buf_count0, 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
